// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and arithmetic helpers for CNN layers
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_RD_DIM,
    S_CHK_DIM,
    S_MAC,
    S_WRITE,
    S_DONE
  } cnn_state_e;

  localparam logic [15:0] CNN_SENTINEL = 16'hFFFF;

  // Accumulator width that cannot overflow for K*K full-scale products.
  function automatic int acc_w(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction

  // Optional ReLU, then clamp to the signed range of a dw-bit word.
  // Works on a 64-bit container so every layer width can share it.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] acc,
                                                  input int dw,
                                                  input logic relu);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (dw - 1));
    if (relu && (acc < 64'sd0)) return 64'sd0;
    else if (acc > max_v) return max_v;
    else if (acc < min_v) return min_v;
    return acc;
  endfunction

endpackage

// File: rtl/cnn_mac_unit.sv
// rtl/cnn_mac_unit.sv - signed multiply-accumulate with saturate/ReLU output stage
module cnn_mac_unit
  import cnn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     acc_valid,
  input  logic                     relu_en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic        [DATA_W-1:0] out_data
);

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc;

  // Full-precision product, sign-extended explicitly to the accumulator width.
  always_comb begin
    a_ext    = $signed({{DATA_W{a[DATA_W-1]}}, a});
    b_ext    = $signed({{DATA_W{b[DATA_W-1]}}, b});
    prod     = a_ext * b_ext;
    prod_ext = $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
  end

  // Accumulate; the first product of a pixel replaces the previous sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (acc_valid) begin
      acc <= clr ? prod_ext : acc + prod_ext;
    end
  end

  // Output stage shared with other layers through the package helper.
  always_comb begin
    out_data = DATA_W'(sat_relu(64'(acc), DATA_W, relu_en));
  end

endmodule

// File: rtl/cnn_conv_engine.sv
// rtl/cnn_conv_engine.sv - walks a matrix list and writes KxK valid convolutions
module cnn_conv_engine
  import cnn_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter int                K        = 3,
  parameter logic [ADDR_W-1:0] OUT_BASE = '0,
  parameter logic [DATA_W-1:0] SENTINEL = CNN_SENTINEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              relu_en,
  output logic              busy,
  output logic [ADDR_W-1:0] Matrix_Address,
  input  logic [DATA_W-1:0] Read_Matrix_Data,
  output logic [ADDR_W-1:0] Weight_Address,
  input  logic [DATA_W-1:0] Read_Weight_Data,
  output logic              Write_Enable,
  output logic [ADDR_W-1:0] Write_Address,
  output logic [DATA_W-1:0] Write_Data
);

  localparam int KK    = K * K;
  localparam int TAP_W = $clog2(KK + 1);
  localparam int ACC_W = acc_w(DATA_W, K);

  cnn_state_e state, state_nx;

  logic                     relu_q;
  logic [TAP_W-1:0]         widx, wcap_idx, tap, mac_widx;
  logic                     wcap_v, mac_v, mac_clr;
  logic [2:0]               i_q, j_q;
  logic [ADDR_W-1:0]        p_q, out_ptr, n_q, r_q, c_q;
  logic signed [DATA_W-1:0] w_q [KK];
  logic [DATA_W-1:0]        mac_out;

  logic [ADDR_W-1:0] dim_a, lim_a, mat_addr, skip_ptr, done_ptr;
  logic              last_col, last_row, tap_end;

  // Address arithmetic, all modulo 2^ADDR_W.
  always_comb begin
    dim_a    = Read_Matrix_Data[ADDR_W-1:0];
    lim_a    = n_q - ADDR_W'(K);
    last_col = (c_q == lim_a);
    last_row = (r_q == lim_a);
    tap_end  = (tap == TAP_W'(KK));
    mat_addr = p_q + ADDR_W'(1) + (r_q + ADDR_W'(i_q)) * n_q + c_q + ADDR_W'(j_q);
    skip_ptr = p_q + ADDR_W'(1) + dim_a * dim_a;
    done_ptr = p_q + ADDR_W'(1) + n_q * n_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and memory-port outputs.
  always_comb begin
    state_nx       = state;
    busy           = (state != S_IDLE);
    Matrix_Address = '0;
    Weight_Address = '0;
    Write_Enable   = 1'b0;
    Write_Address  = '0;
    Write_Data     = '0;
    case (state)
      S_IDLE:   if (go) state_nx = S_LOAD_W;
      S_LOAD_W: begin
        Weight_Address = ADDR_W'(widx);
        if (widx == TAP_W'(KK - 1)) state_nx = S_RD_DIM;
      end
      S_RD_DIM: begin
        Matrix_Address = p_q;
        state_nx       = S_CHK_DIM;
      end
      S_CHK_DIM: begin
        if (Read_Matrix_Data == SENTINEL)          state_nx = S_DONE;
        else if (Read_Matrix_Data < DATA_W'(K))    state_nx = S_RD_DIM;
        else                                       state_nx = S_MAC;
      end
      S_MAC: begin
        Matrix_Address = mat_addr;
        if (tap_end) state_nx = S_WRITE;
      end
      S_WRITE: begin
        Write_Enable  = 1'b1;
        Write_Address = out_ptr;
        Write_Data    = mac_out;
        state_nx      = (last_col && last_row) ? S_RD_DIM : S_MAC;
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Pointers, window counters and the 1-cycle read-latency pipeline.
  // Each accepted go restarts the list at 0 and packs outputs from OUT_BASE.
  always_ff @(posedge clk) begin
    if (reset) begin
      relu_q   <= 1'b0;
      widx     <= '0;
      wcap_v   <= 1'b0;
      wcap_idx <= '0;
      mac_v    <= 1'b0;
      mac_clr  <= 1'b0;
      mac_widx <= '0;
      p_q      <= '0;
      out_ptr  <= OUT_BASE;
      n_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      tap      <= '0;
    end else begin
      wcap_v   <= (state == S_LOAD_W);
      wcap_idx <= widx;
      mac_v    <= (state == S_MAC) && !tap_end;
      mac_clr  <= (tap == '0);
      if ((state == S_MAC) && !tap_end) mac_widx <= tap;
      case (state)
        S_IDLE: begin
          if (go) begin
            relu_q  <= relu_en;
            widx    <= '0;
            p_q     <= '0;
            out_ptr <= OUT_BASE;
          end
        end
        S_LOAD_W: widx <= widx + TAP_W'(1);
        S_CHK_DIM: begin
          n_q <= dim_a;
          r_q <= '0;
          c_q <= '0;
          i_q <= '0;
          j_q <= '0;
          tap <= '0;
          if ((Read_Matrix_Data != SENTINEL) && (Read_Matrix_Data < DATA_W'(K)))
            p_q <= skip_ptr;
        end
        S_MAC: begin
          if (!tap_end) begin
            tap <= tap + TAP_W'(1);
            if (j_q == 3'(K - 1)) begin
              j_q <= '0;
              i_q <= i_q + 3'd1;
            end else begin
              j_q <= j_q + 3'd1;
            end
          end
        end
        S_WRITE: begin
          out_ptr <= out_ptr + ADDR_W'(1);
          tap     <= '0;
          i_q     <= '0;
          j_q     <= '0;
          if (last_col) begin
            c_q <= '0;
            if (last_row) p_q <= done_ptr;
            else          r_q <= r_q + ADDR_W'(1);
          end else begin
            c_q <= c_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Kernel register file, filled one cycle behind each weight address.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < KK; k++) w_q[k] <= '0;
    end else if (wcap_v) begin
      w_q[wcap_idx] <= Read_Weight_Data;
    end
  end

  cnn_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clr       (mac_clr),
    .acc_valid (mac_v),
    .relu_en   (relu_q),
    .a         (Read_Matrix_Data),
    .b         (w_q[mac_widx]),
    .out_data  (mac_out)
  );

endmodule

// File: tb/tb_cnn_conv_engine.sv
// tb/tb_cnn_conv_engine.sv - directed self-checking bench for cnn_conv_engine
module tb_cnn_conv_engine;

  logic        clk;
  logic        reset;
  logic        go;
  logic        relu_en;
  logic        busy;
  logic [11:0] Matrix_Address;
  logic [15:0] Read_Matrix_Data;
  logic [11:0] Weight_Address;
  logic [15:0] Read_Weight_Data;
  logic        Write_Enable;
  logic [11:0] Write_Address;
  logic [15:0] Write_Data;

  logic [15:0] imem [0:4095];
  logic [15:0] wmem [0:4095];
  logic [11:0] wa   [0:63];
  logic [15:0] wd   [0:63];
  int          wcyc [0:63];
  logic [15:0] ex   [0:15];
  int          nw;
  int          cyc;
  int          checks;
  int          errors;

  cnn_conv_engine dut (
    .clk              (clk),
    .reset            (reset),
    .go               (go),
    .relu_en          (relu_en),
    .busy             (busy),
    .Matrix_Address   (Matrix_Address),
    .Read_Matrix_Data (Read_Matrix_Data),
    .Weight_Address   (Weight_Address),
    .Read_Weight_Data (Read_Weight_Data),
    .Write_Enable     (Write_Enable),
    .Write_Address    (Write_Address),
    .Write_Data       (Write_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM models with one cycle of read latency.
  always @(posedge clk) begin
    cyc++;
    Read_Matrix_Data <= imem[Matrix_Address];
    Read_Weight_Data <= wmem[Weight_Address];
  end

  // Output SRAM write log.
  always @(negedge clk) begin
    if (Write_Enable && nw < 64) begin
      wa[nw]   = Write_Address;
      wd[nw]   = Write_Data;
      wcyc[nw] = cyc;
      nw++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 4096; k++) begin
      imem[k] = 16'h0;
      wmem[k] = 16'h0;
    end
  endtask

  task automatic set_w(input logic [15:0] v);
    for (int k = 0; k < 9; k++) wmem[k] = v;
  endtask

  task automatic load_ramp4();
    imem[0] = 16'd4;
    for (int k = 1; k <= 16; k++) imem[k] = 16'(k);
    imem[17] = 16'hFFFF;
  endtask

  task automatic start_go(input logic relu);
    @(negedge clk);
    nw      = 0;
    go      = 1'b1;
    relu_en = relu;
    @(negedge clk);
    go      = 1'b0;
    relu_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " busy_drop"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input logic relu, input string tag);
    start_go(relu);
    wait_idle(tag);
  endtask

  task automatic check_writes(input string tag, input int cnt);
    check({tag, " count"}, 32'(nw), 32'(cnt));
    for (int k = 0; k < cnt && k < nw; k++) begin
      check($sformatf("%s addr%0d", tag, k), 32'(wa[k]), 32'(k));
      check($sformatf("%s data%0d", tag, k), 32'(wd[k]), 32'(ex[k]));
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    nw      = 0;
    cyc     = 0;
    reset   = 1'b1;
    go      = 1'b0;
    relu_en = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst we", 32'(Write_Enable), 32'd0);
    check("rst maddr", 32'(Matrix_Address), 32'd0);
    check("rst waddr", 32'(Weight_Address), 32'd0);
    check("rst wraddr", 32'(Write_Address), 32'd0);
    check("rst wrdata", 32'(Write_Data), 32'd0);
    reset = 1'b0;

    // Basic 4x4 ramp, unit kernel.
    load_ramp4();
    set_w(16'd1);
    run(1'b0, "t1");
    ex[0] = 16'd54; ex[1] = 16'd63; ex[2] = 16'd90; ex[3] = 16'd99;
    check_writes("t1", 4);
    check("t1 pixel_period", 32'(wcyc[1] - wcyc[0]), 32'd11);

    // Negative kernel with and without ReLU.
    set_w(16'hFFFF);
    run(1'b1, "t2r");
    ex[0] = 16'd0; ex[1] = 16'd0; ex[2] = 16'd0; ex[3] = 16'd0;
    check_writes("t2r", 4);
    run(1'b0, "t2n");
    ex[0] = 16'hFFCA; ex[1] = 16'hFFC1; ex[2] = 16'hFFA6; ex[3] = 16'hFF9D;
    check_writes("t2n", 4);

    // Saturation at both rails.
    clear_mem();
    imem[0] = 16'd3;
    for (int k = 1; k <= 9; k++) imem[k] = 16'h7FFF;
    imem[10] = 16'hFFFF;
    set_w(16'h7FFF);
    run(1'b0, "t3p");
    ex[0] = 16'h7FFF;
    check_writes("t3p", 1);
    for (int k = 1; k <= 9; k++) imem[k] = 16'h8000;
    set_w(16'd1);
    run(1'b0, "t3n");
    ex[0] = 16'h8000;
    check_writes("t3n", 1);

    // Mixed list: N=2 skipped, N=3, N=5.
    clear_mem();
    imem[0] = 16'd2;
    for (int k = 1; k <= 4; k++) imem[k] = 16'd100;
    imem[5] = 16'd3;
    for (int k = 1; k <= 9; k++) imem[5 + k] = 16'(k);
    imem[15] = 16'd5;
    for (int k = 1; k <= 25; k++) imem[15 + k] = 16'(k);
    imem[41] = 16'hFFFF;
    set_w(16'd1);
    run(1'b0, "t4");
    ex[0] = 16'd45;  ex[1] = 16'd63;  ex[2] = 16'd72;  ex[3] = 16'd81;
    ex[4] = 16'd108; ex[5] = 16'd117; ex[6] = 16'd126;
    ex[7] = 16'd153; ex[8] = 16'd162; ex[9] = 16'd171;
    check_writes("t4", 10);

    // Reset during the second pixel, then restart with a new kernel.
    clear_mem();
    load_ramp4();
    set_w(16'd1);
    start_go(1'b0);
    for (int n = 0; n < 500 && nw < 1; n++) @(negedge clk);
    check("t5 first_write", 32'(nw), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5 busy_after_rst", 32'(busy), 32'd0);
    check("t5 we_after_rst", 32'(Write_Enable), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("t5 no_more_writes", 32'(nw), 32'd1);
    set_w(16'd2);
    start_go(1'b0);
    check("t5 wreload0", 32'(Weight_Address), 32'd0);
    @(negedge clk);
    check("t5 wreload1", 32'(Weight_Address), 32'd1);
    wait_idle("t5");
    ex[0] = 16'd108; ex[1] = 16'd126; ex[2] = 16'd180; ex[3] = 16'd198;
    check_writes("t5", 4);

    // go pulses while busy must be ignored.
    set_w(16'd1);
    start_go(1'b0);
    repeat (5) @(negedge clk);
    go = 1'b1; relu_en = 1'b1;
    @(negedge clk);
    go = 1'b0; relu_en = 1'b0;
    repeat (20) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_idle("t6");
    ex[0] = 16'd54; ex[1] = 16'd63; ex[2] = 16'd90; ex[3] = 16'd99;
    check_writes("t6", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
